// File: rtl/bounding_box_finder.sv
`default_nettype none
// ============================================================================
//  Module   : bounding_box_finder
//  Purpose  : Tracks the axis-aligned bounding box of the foreground (mask)
//             pixels in each frame and publishes it once per frame. The box
//             has an inclusive min corner and an exclusive max corner.
//  Revision : 1.0 - initial release
// ============================================================================
module bounding_box_finder #(
   parameter int H_ACTIVE   = 1280,
   parameter int V_ACTIVE   = 720,
   parameter int MIN_PIXELS = 16
) (
   input  logic        clk_in,
   input  logic        rst_n_in,
   input  logic [10:0] hcount_in,
   input  logic [9:0]  vcount_in,
   input  logic        valid_in,
   input  logic        mask_in,
   input  logic        new_frame_in,
   output logic [10:0] x_min_out,
   output logic [9:0]  y_min_out,
   output logic [10:0] x_max_out,
   output logic [9:0]  y_max_out,
   output logic [19:0] count_out,
   output logic        box_valid_out,
   output logic        frame_done_out
);

   localparam logic [0:0]  S_WAIT  = 1'b0;
   localparam logic [0:0]  S_ACCUM = 1'b1;

   localparam logic [10:0] c_h_active   = 11'(H_ACTIVE);
   localparam logic [9:0]  c_v_active   = 10'(V_ACTIVE);
   localparam logic [19:0] c_min_pixels = 20'(MIN_PIXELS);
   localparam logic [19:0] c_cnt_max    = 20'hF_FFFF;

   logic [0:0]  r_state;
   logic [0:0]  w_state_next;
   logic        w_accum_on;
   logic        w_publish;
   logic        w_qual;

   logic [10:0] r_xmin;
   logic [9:0]  r_ymin;
   logic [10:0] r_xmax;
   logic [9:0]  r_ymax;
   logic [19:0] r_cnt;
   logic        r_seen;

   logic [10:0] r_x_min;
   logic [9:0]  r_y_min;
   logic [10:0] r_x_max;
   logic [9:0]  r_y_max;
   logic [19:0] r_count;
   logic        r_box_valid;
   logic        r_frame_done;

   // A pixel contributes only when it is valid, foreground and inside the active area
   assign w_qual = valid_in && mask_in && (hcount_in < c_h_active) && (vcount_in < c_v_active);

   // State register
   always_ff @(posedge clk_in) begin
      if (!rst_n_in) r_state <= S_WAIT;
      else           r_state <= w_state_next;
   end

   // Next state: the first frame marker leaves WAIT; ACCUM is then permanent
   always_comb begin
      w_state_next = r_state;
      if (r_state == S_WAIT && new_frame_in) w_state_next = S_ACCUM;
   end

   // FSM outputs: accumulate in ACCUM, publish on every frame marker seen in ACCUM
   always_comb begin
      w_accum_on = 1'b0;
      w_publish  = 1'b0;
      if (r_state == S_ACCUM) begin
         w_accum_on = 1'b1;
         w_publish  = new_frame_in;
      end
   end

   // Accumulators; a pixel arriving with the frame marker seeds the new frame
   always_ff @(posedge clk_in) begin
      if (!rst_n_in) begin
         r_xmin <= '0;
         r_ymin <= '0;
         r_xmax <= '0;
         r_ymax <= '0;
         r_cnt  <= '0;
         r_seen <= 1'b0;
      end else if (new_frame_in) begin
         r_xmin <= w_qual ? hcount_in : 11'd0;
         r_ymin <= w_qual ? vcount_in : 10'd0;
         r_xmax <= w_qual ? hcount_in : 11'd0;
         r_ymax <= w_qual ? vcount_in : 10'd0;
         r_cnt  <= w_qual ? 20'd1 : 20'd0;
         r_seen <= w_qual;
      end else if (w_accum_on && w_qual) begin
         if (!r_seen) begin
            r_xmin <= hcount_in;
            r_ymin <= vcount_in;
            r_xmax <= hcount_in;
            r_ymax <= vcount_in;
            r_cnt  <= 20'd1;
            r_seen <= 1'b1;
         end else begin
            if (hcount_in < r_xmin) r_xmin <= hcount_in;
            if (vcount_in < r_ymin) r_ymin <= vcount_in;
            if (hcount_in > r_xmax) r_xmax <= hcount_in;
            if (vcount_in > r_ymax) r_ymax <= vcount_in;
            if (r_cnt != c_cnt_max) r_cnt <= r_cnt + 20'd1;
         end
      end
   end

   // Publish registers; max edges become exclusive (+1 cannot overflow the port width)
   always_ff @(posedge clk_in) begin
      if (!rst_n_in) begin
         r_x_min      <= '0;
         r_y_min      <= '0;
         r_x_max      <= '0;
         r_y_max      <= '0;
         r_count      <= '0;
         r_box_valid  <= 1'b0;
         r_frame_done <= 1'b0;
      end else begin
         r_frame_done <= w_publish;
         if (w_publish) begin
            r_count <= r_cnt;
            if (r_seen && (r_cnt >= c_min_pixels)) begin
               r_x_min     <= r_xmin;
               r_y_min     <= r_ymin;
               r_x_max     <= r_xmax + 11'd1;
               r_y_max     <= r_ymax + 10'd1;
               r_box_valid <= 1'b1;
            end else begin
               r_x_min     <= '0;
               r_y_min     <= '0;
               r_x_max     <= '0;
               r_y_max     <= '0;
               r_box_valid <= 1'b0;
            end
         end
      end
   end

   assign x_min_out      = r_x_min;
   assign y_min_out      = r_y_min;
   assign x_max_out      = r_x_max;
   assign y_max_out      = r_y_max;
   assign count_out      = r_count;
   assign box_valid_out  = r_box_valid;
   assign frame_done_out = r_frame_done;

endmodule
`default_nettype wire

// File: tb/tb_bounding_box_finder.sv
`default_nettype none
// ============================================================================
//  Module   : tb_bounding_box_finder
//  Purpose  : Self-checking bench for bounding_box_finder. Each scenario task
//             pushes the frame result it expects; a monitor pops and compares
//             on every frame_done pulse.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_bounding_box_finder;

   typedef struct {
      string       name;
      logic [10:0] x_min;
      logic [9:0]  y_min;
      logic [10:0] x_max;
      logic [9:0]  y_max;
      logic [19:0] count;
      logic        valid;
   } exp_t;

   logic        clk_in = 1'b0;
   logic        rst_n_in = 1'b0;
   logic [10:0] hcount_in = '0;
   logic [9:0]  vcount_in = '0;
   logic        valid_in = 1'b0;
   logic        mask_in = 1'b0;
   logic        new_frame_in = 1'b0;
   logic [10:0] x_min_out;
   logic [9:0]  y_min_out;
   logic [10:0] x_max_out;
   logic [9:0]  y_max_out;
   logic [19:0] count_out;
   logic        box_valid_out;
   logic        frame_done_out;

   exp_t sb_q[$];
   int   n_checks = 0;
   int   n_fail   = 0;

   bounding_box_finder #(
      .H_ACTIVE   (1280),
      .V_ACTIVE   (720),
      .MIN_PIXELS (16)
   ) dut (
      .clk_in         (clk_in),
      .rst_n_in       (rst_n_in),
      .hcount_in      (hcount_in),
      .vcount_in      (vcount_in),
      .valid_in       (valid_in),
      .mask_in        (mask_in),
      .new_frame_in   (new_frame_in),
      .x_min_out      (x_min_out),
      .y_min_out      (y_min_out),
      .x_max_out      (x_max_out),
      .y_max_out      (y_max_out),
      .count_out      (count_out),
      .box_valid_out  (box_valid_out),
      .frame_done_out (frame_done_out)
   );

   always #5 clk_in = ~clk_in;

   // Scoreboard: every frame_done pulse must match the oldest expected frame
   always @(negedge clk_in) begin
      if (rst_n_in && frame_done_out) begin
         n_checks++;
         if (sb_q.size() == 0) begin
            n_fail++;
            $display("FAIL sb_unexpected_frame_done: got frame_done=1 required no publish");
         end else begin
            exp_t e;
            e = sb_q.pop_front();
            if ({x_min_out, y_min_out, x_max_out, y_max_out} !== {e.x_min, e.y_min, e.x_max, e.y_max}) begin
               n_fail++;
               $display("FAIL %s_box: got (%0d,%0d)-(%0d,%0d) required (%0d,%0d)-(%0d,%0d)", e.name,
                        x_min_out, y_min_out, x_max_out, y_max_out, e.x_min, e.y_min, e.x_max, e.y_max);
            end
            n_checks++;
            if (count_out !== e.count) begin
               n_fail++;
               $display("FAIL %s_count: got %0d required %0d", e.name, count_out, e.count);
            end
            n_checks++;
            if (box_valid_out !== e.valid) begin
               n_fail++;
               $display("FAIL %s_box_valid: got %0b required %0b", e.name, box_valid_out, e.valid);
            end
         end
      end
   end

   task automatic push_exp(input string nm, input int xn, input int yn, input int xx, input int yx,
                           input int c, input bit v);
      exp_t e;
      e.name = nm; e.x_min = 11'(xn); e.y_min = 10'(yn); e.x_max = 11'(xx); e.y_max = 10'(yx);
      e.count = 20'(c); e.valid = v;
      sb_q.push_back(e);
   endtask

   task automatic drive_px(input int x, input int y, input bit v, input bit m);
      hcount_in = 11'(x); vcount_in = 10'(y); valid_in = v; mask_in = m;
      @(posedge clk_in); #1;
      valid_in = 1'b0; mask_in = 1'b0;
   endtask

   task automatic frame_mark(input bit with_px, input int x, input int y);
      new_frame_in = 1'b1;
      hcount_in = 11'(x); vcount_in = 10'(y); valid_in = with_px; mask_in = with_px;
      @(posedge clk_in); #1;
      new_frame_in = 1'b0; valid_in = 1'b0; mask_in = 1'b0;
   endtask

   // Bounded wait until the monitor has consumed every expected frame
   task automatic wait_drain(input string nm);
      int k = 0;
      while (sb_q.size() != 0 && k < 10) begin
         @(negedge clk_in); k++;
      end
      @(negedge clk_in);
      n_checks++;
      if (sb_q.size() != 0) begin
         n_fail++;
         $display("FAIL %s_timeout: got %0d pending frames required 0", nm, sb_q.size());
         sb_q.delete();
      end
   endtask

   task automatic test_reset();
      rst_n_in = 1'b0;
      repeat (3) @(posedge clk_in);
      @(negedge clk_in);
      n_checks++;
      if ({x_min_out, y_min_out, x_max_out, y_max_out} !== 42'd0) begin
         n_fail++;
         $display("FAIL reset_coords: got (%0d,%0d)-(%0d,%0d) required all 0",
                  x_min_out, y_min_out, x_max_out, y_max_out);
      end
      n_checks++;
      if ({count_out, box_valid_out, frame_done_out} !== 22'd0) begin
         n_fail++;
         $display("FAIL reset_status: got count=%0d valid=%0b done=%0b required 0",
                  count_out, box_valid_out, frame_done_out);
      end
      #1 rst_n_in = 1'b1;
      @(posedge clk_in); #1;
      // First marker after reset is taken in WAIT and must not publish
      frame_mark(1'b0, 0, 0);
      @(negedge clk_in);
      n_checks++;
      if (frame_done_out !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_first_marker: got frame_done=%0b required 0", frame_done_out);
      end
   endtask

   task automatic test_block();
      drive_px(99, 50, 1'b1, 1'b0);
      drive_px(120, 59, 1'b1, 1'b0);
      for (int y = 50; y < 60; y++)
         for (int x = 100; x < 120; x++)
            drive_px(x, y, 1'b1, 1'b1);
      push_exp("block", 100, 50, 120, 60, 200, 1'b1);
      frame_mark(1'b0, 0, 0);
      // The pulse is visible in the cycle right after the marker and lasts one cycle
      @(negedge clk_in);
      n_checks++;
      if (frame_done_out !== 1'b1) begin
         n_fail++;
         $display("FAIL block_latency: got frame_done=%0b required 1", frame_done_out);
      end
      @(negedge clk_in);
      n_checks++;
      if (frame_done_out !== 1'b0) begin
         n_fail++;
         $display("FAIL block_pulse_width: got frame_done=%0b required 0", frame_done_out);
      end
      wait_drain("block");
   endtask

   task automatic test_small();
      for (int i = 0; i < 5; i++) drive_px(300 + i, 200, 1'b1, 1'b1);
      push_exp("small", 0, 0, 0, 0, 5, 1'b0);
      frame_mark(1'b0, 0, 0);
      wait_drain("small");
   endtask

   task automatic test_corner();
      drive_px(1279, 719, 1'b1, 1'b1);
      drive_px(1280, 5, 1'b1, 1'b1);
      drive_px(5, 720, 1'b1, 1'b1);
      for (int i = 0; i < 15; i++) drive_px(0, 0, 1'b1, 1'b1);
      push_exp("corner", 0, 0, 1280, 720, 16, 1'b1);
      frame_mark(1'b0, 0, 0);
      wait_drain("corner");
   endtask

   task automatic test_mid_reset();
      for (int i = 0; i < 100; i++) drive_px(400 + (i % 10), 100 + (i / 10), 1'b1, 1'b1);
      rst_n_in = 1'b0;
      repeat (2) @(posedge clk_in);
      #1 rst_n_in = 1'b1;
      @(negedge clk_in);
      n_checks++;
      if ({x_min_out, y_min_out, x_max_out, y_max_out, count_out, box_valid_out} !== 63'd0) begin
         n_fail++;
         $display("FAIL midreset_outputs: got (%0d,%0d)-(%0d,%0d) count=%0d valid=%0b required all 0",
                  x_min_out, y_min_out, x_max_out, y_max_out, count_out, box_valid_out);
      end
      @(posedge clk_in); #1;
      frame_mark(1'b0, 0, 0);
      @(negedge clk_in);
      n_checks++;
      if (frame_done_out !== 1'b0) begin
         n_fail++;
         $display("FAIL midreset_no_publish: got frame_done=%0b required 0", frame_done_out);
      end
   endtask

   task automatic test_same_cycle();
      for (int i = 0; i < 20; i++) drive_px(200 + i, 300, 1'b1, 1'b1);
      push_exp("same_cycle_prev", 200, 300, 220, 301, 20, 1'b1);
      frame_mark(1'b1, 7, 3);
      for (int i = 0; i < 15; i++) drive_px(50, 40, 1'b1, 1'b1);
      push_exp("same_cycle_next", 7, 3, 51, 41, 16, 1'b1);
      frame_mark(1'b0, 0, 0);
      wait_drain("same_cycle");
   endtask

   task automatic test_back_to_back();
      for (int i = 0; i < 16; i++) drive_px(10, 10, 1'b1, 1'b1);
      push_exp("b2b_first", 10, 10, 11, 11, 16, 1'b1);
      push_exp("b2b_empty", 0, 0, 0, 0, 0, 1'b0);
      new_frame_in = 1'b1;
      repeat (2) @(posedge clk_in);
      #1 new_frame_in = 1'b0;
      wait_drain("b2b");
   endtask

   task automatic test_invalid_mask();
      for (int i = 0; i < 40; i++) drive_px(600 + i, 500, 1'b0, 1'b1);
      push_exp("invalid_mask", 0, 0, 0, 0, 0, 1'b0);
      frame_mark(1'b0, 0, 0);
      wait_drain("invalid_mask");
   endtask

   initial begin
      test_reset();
      test_block();
      test_small();
      test_corner();
      test_mid_reset();
      test_same_cycle();
      test_back_to_back();
      test_invalid_mask();
      repeat (3) @(negedge clk_in);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
